// File: rtl/counter_loop_nested.sv
// Two-level inner/outer loop counter with start/done handshake; limits latched on start.
// Optional build macro COUNTER_LOOP_NESTED_STEP_EN adds a programmable inner step.
module counter_loop_nested #(
  parameter int INNER_WIDTH = 8,
  parameter int OUTER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   en,
`ifdef COUNTER_LOOP_NESTED_STEP_EN
  input  logic [INNER_WIDTH-1:0] inner_step,
`endif
  input  logic [INNER_WIDTH-1:0] inner_limit,
  input  logic [OUTER_WIDTH-1:0] outer_limit,
  output logic [INNER_WIDTH-1:0] inner_cnt,
  output logic [OUTER_WIDTH-1:0] outer_cnt,
  output logic                   inner_last,
  output logic                   outer_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [INNER_WIDTH-1:0] INNER_ZERO = '0;
  localparam logic [OUTER_WIDTH-1:0] OUTER_ZERO = '0;
  localparam logic [OUTER_WIDTH-1:0] OUTER_ONE  = OUTER_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [INNER_WIDTH-1:0] inner_cnt_q, inner_cnt_d;
  logic [OUTER_WIDTH-1:0] outer_cnt_q, outer_cnt_d;
  logic [INNER_WIDTH-1:0] inner_lim_q, inner_lim_d;
  logic [OUTER_WIDTH-1:0] outer_lim_q, outer_lim_d;
  logic [INNER_WIDTH-1:0] step;
  logic                   inner_term;

`ifdef COUNTER_LOOP_NESTED_STEP_EN
  logic [INNER_WIDTH-1:0] step_q, step_d;
  logic [INNER_WIDTH:0]   inner_room;

  // A latched step of zero would stall the sweep forever, so it is promoted to one.
  assign step       = (step_q == INNER_ZERO) ? INNER_WIDTH'(1) : step_q;
  assign inner_room = {1'b0, inner_lim_q} - {1'b0, inner_cnt_q};
  assign inner_term = inner_room < {1'b0, step};
`else
  assign step       = INNER_WIDTH'(1);
  assign inner_term = (inner_cnt_q == inner_lim_q);
`endif

  assign inner_cnt  = inner_cnt_q;
  assign outer_cnt  = outer_cnt_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign inner_last = busy & inner_term;
  assign outer_last = inner_last & (outer_cnt_q == outer_lim_q);

  always_comb begin
    state_d     = state_q;
    inner_cnt_d = inner_cnt_q;
    outer_cnt_d = outer_cnt_q;
    inner_lim_d = inner_lim_q;
    outer_lim_d = outer_lim_q;
`ifdef COUNTER_LOOP_NESTED_STEP_EN
    step_d      = step_q;
`endif
    case (state_q)
      RUN: begin
        if (en) begin
          if (!inner_term) begin
            inner_cnt_d = inner_cnt_q + step;
          end else if (outer_cnt_q != outer_lim_q) begin
            inner_cnt_d = INNER_ZERO;
            outer_cnt_d = outer_cnt_q + OUTER_ONE;
          end else begin
            inner_cnt_d = INNER_ZERO;
            outer_cnt_d = OUTER_ZERO;
            state_d     = DONE;
          end
        end
      end
      IDLE, DONE: begin
        inner_cnt_d = INNER_ZERO;
        outer_cnt_d = OUTER_ZERO;
        state_d     = IDLE;
        if (start) begin
          inner_lim_d = inner_limit;
          outer_lim_d = outer_limit;
`ifdef COUNTER_LOOP_NESTED_STEP_EN
          step_d      = inner_step;
`endif
          state_d     = RUN;
        end
      end
      default: begin
        inner_cnt_d = INNER_ZERO;
        outer_cnt_d = OUTER_ZERO;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inner_cnt_q <= INNER_ZERO;
      outer_cnt_q <= OUTER_ZERO;
      inner_lim_q <= INNER_ZERO;
      outer_lim_q <= OUTER_ZERO;
`ifdef COUNTER_LOOP_NESTED_STEP_EN
      step_q      <= INNER_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      inner_cnt_q <= inner_cnt_d;
      outer_cnt_q <= outer_cnt_d;
      inner_lim_q <= inner_lim_d;
      outer_lim_q <= outer_lim_d;
`ifdef COUNTER_LOOP_NESTED_STEP_EN
      step_q      <= step_d;
`endif
    end
  end

endmodule

// File: tb/tb_counter_loop_nested.sv
// Directed self-checking bench for counter_loop_nested: an 8-bit instance for the
// sweep/handshake scenarios and a 4-bit instance for the all-ones limit sweep.
module tb_counter_loop_nested;

  logic       clk;
  logic       rst;
  logic       start, en;
  logic [7:0] inner_limit, outer_limit;
  logic [7:0] inner_cnt, outer_cnt;
  logic       inner_last, outer_last, busy, done;

  logic       start4, en4;
  logic [3:0] inner_limit4, outer_limit4;
  logic [3:0] inner_cnt4, outer_cnt4;
  logic       inner_last4, outer_last4, busy4, done4;

`ifdef COUNTER_LOOP_NESTED_STEP_EN
  logic [7:0] inner_step;
  logic [3:0] inner_step4;
`endif

  int errors = 0;
  int checks = 0;

  counter_loop_nested #(.INNER_WIDTH(8), .OUTER_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
`ifdef COUNTER_LOOP_NESTED_STEP_EN
    .inner_step(inner_step),
`endif
    .inner_limit(inner_limit), .outer_limit(outer_limit),
    .inner_cnt(inner_cnt), .outer_cnt(outer_cnt),
    .inner_last(inner_last), .outer_last(outer_last),
    .busy(busy), .done(done)
  );

  counter_loop_nested #(.INNER_WIDTH(4), .OUTER_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .en(en4),
`ifdef COUNTER_LOOP_NESTED_STEP_EN
    .inner_step(inner_step4),
`endif
    .inner_limit(inner_limit4), .outer_limit(outer_limit4),
    .inner_cnt(inner_cnt4), .outer_cnt(outer_cnt4),
    .inner_last(inner_last4), .outer_last(outer_last4),
    .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [7:0] il, input logic [7:0] ol);
    inner_limit = il;
    outer_limit = ol;
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  logic [7:0] exp_inner [6];
  logic [7:0] exp_outer [6];
  int         acc;

  initial begin
    exp_inner = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    exp_outer = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    rst = 1'b1; start = 1'b0; en = 1'b0; inner_limit = '0; outer_limit = '0;
    start4 = 1'b0; en4 = 1'b0; inner_limit4 = '0; outer_limit4 = '0;
`ifdef COUNTER_LOOP_NESTED_STEP_EN
    inner_step = 8'd1; inner_step4 = 4'd0;
`endif
    applyStimulus(2);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_inner", {24'd0, inner_cnt}, 32'd0);
    checkOutput("reset_outer", {24'd0, outer_cnt}, 32'd0);
    checkOutput("reset_inner_last", {31'd0, inner_last}, 32'd0);
    rst = 1'b0;
    applyStimulus(1);

    // Continuous sweep 3 x 2
    launch(8'd2, 8'd1);
    checkOutput("sweep_busy", {31'd0, busy}, 32'd1);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("sweep_inner", {24'd0, inner_cnt}, {24'd0, exp_inner[k]});
      checkOutput("sweep_outer", {24'd0, outer_cnt}, {24'd0, exp_outer[k]});
      checkOutput("sweep_done_low", {31'd0, done}, 32'd0);
      checkOutput("sweep_inner_last", {31'd0, inner_last}, {31'd0, exp_inner[k] == 8'd2});
      checkOutput("sweep_outer_last", {31'd0, outer_last}, {31'd0, k == 5});
      applyStimulus(1);
    end
    checkOutput("sweep_done", {31'd0, done}, 32'd1);
    checkOutput("sweep_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("sweep_done_inner", {24'd0, inner_cnt}, 32'd0);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("sweep_done_once", {31'd0, done}, 32'd0);
    checkOutput("sweep_idle_busy", {31'd0, busy}, 32'd0);

    // Gapped enable: one step every third cycle
    launch(8'd2, 8'd1);
    acc = 0;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      en = (c % 3 == 0);
      checkOutput("gap_inner", {24'd0, inner_cnt}, acc % 3);
      checkOutput("gap_outer", {24'd0, outer_cnt}, acc / 3);
      checkOutput("gap_done_low", {31'd0, done}, 32'd0);
      applyStimulus(1);
      if (en) acc++;
    end
    checkOutput("gap_steps", acc, 32'd6);
    checkOutput("gap_done", {31'd0, done}, 32'd1);
    en = 1'b0;
    applyStimulus(1);

    // Zero limits, then restart straight out of DONE
    launch(8'd0, 8'd0);
    en = 1'b1;
    checkOutput("zero_inner_last", {31'd0, inner_last}, 32'd1);
    checkOutput("zero_outer_last", {31'd0, outer_last}, 32'd1);
    applyStimulus(1);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    en = 1'b0;
    launch(8'd1, 8'd0);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    checkOutput("restart_done_low", {31'd0, done}, 32'd0);
    en = 1'b1;
    checkOutput("restart_inner0", {24'd0, inner_cnt}, 32'd0);
    applyStimulus(1);
    checkOutput("restart_inner1", {24'd0, inner_cnt}, 32'd1);
    applyStimulus(1);
    checkOutput("restart_done", {31'd0, done}, 32'd1);
    en = 1'b0;
    applyStimulus(1);

    // Start pulse and new limits during RUN are ignored
    launch(8'd2, 8'd1);
    en = 1'b1;
    applyStimulus(1);
    inner_limit = 8'd5; outer_limit = 8'd5; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("midrun_inner", {24'd0, inner_cnt}, 32'd2);
    checkOutput("midrun_outer", {24'd0, outer_cnt}, 32'd0);
    applyStimulus(1);
    checkOutput("midrun_wrap_inner", {24'd0, inner_cnt}, 32'd0);
    checkOutput("midrun_wrap_outer", {24'd0, outer_cnt}, 32'd1);
    applyStimulus(3);
    checkOutput("midrun_done", {31'd0, done}, 32'd1);
    en = 1'b0;
    applyStimulus(1);

    // Reset in the middle of a sweep
    launch(8'd2, 8'd1);
    en = 1'b1;
    applyStimulus(2);
    checkOutput("rstmid_pre_inner", {24'd0, inner_cnt}, 32'd2);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_inner", {24'd0, inner_cnt}, 32'd0);
    checkOutput("rstmid_outer", {24'd0, outer_cnt}, 32'd0);
    checkOutput("rstmid_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("rstmid_no_done", {31'd0, done}, 32'd0);
    checkOutput("rstmid_idle", {31'd0, busy}, 32'd0);
    en = 1'b0;

    // All-ones limits on the 4-bit instance: 256 steps
    inner_limit4 = 4'hF; outer_limit4 = 4'hF; start4 = 1'b1;
    applyStimulus(1);
    start4 = 1'b0;
    en4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      checkOutput("wide_inner", {28'd0, inner_cnt4}, i % 16);
      checkOutput("wide_outer", {28'd0, outer_cnt4}, i / 16);
      checkOutput("wide_done_low", {31'd0, done4}, 32'd0);
      applyStimulus(1);
    end
    checkOutput("wide_done", {31'd0, done4}, 32'd1);
    checkOutput("wide_busy", {31'd0, busy4}, 32'd0);
    en4 = 1'b0;
    applyStimulus(1);

`ifdef COUNTER_LOOP_NESTED_STEP_EN
    // Step of 3 against limit 7: 0,3,6 then done
    inner_step = 8'd3;
    launch(8'd7, 8'd0);
    en = 1'b1;
    checkOutput("step3_0", {24'd0, inner_cnt}, 32'd0);
    applyStimulus(1);
    checkOutput("step3_3", {24'd0, inner_cnt}, 32'd3);
    applyStimulus(1);
    checkOutput("step3_6", {24'd0, inner_cnt}, 32'd6);
    checkOutput("step3_last", {31'd0, inner_last}, 32'd1);
    applyStimulus(1);
    checkOutput("step3_done", {31'd0, done}, 32'd1);
    checkOutput("step3_wrap", {24'd0, inner_cnt}, 32'd0);
    en = 1'b0;
    applyStimulus(1);

    // Step of 0 behaves as 1
    inner_step = 8'd0;
    launch(8'd2, 8'd0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("step0_inner", {24'd0, inner_cnt}, k);
      checkOutput("step0_done_low", {31'd0, done}, 32'd0);
      applyStimulus(1);
    end
    checkOutput("step0_done", {31'd0, done}, 32'd1);
    en = 1'b0;
    applyStimulus(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
